debounced_code_lock: RTL
========================

// Module: debounced_code_lock
// PURPOSE
//  Parametrised successor to the 2-bit shift-debounced switch-compare stepper.
//  Raw step_in passes a DEBOUNCE_LEN-deep shift debouncer with hysteresis; each clean
//  press compares code_in against the next entry of CODE_SEQ. A full correct sequence
//  opens the lock for OPEN_CYCLES; MAX_FAILS consecutive misses force a LOCKOUT_CYCLES
//  lockout. Sits directly behind the io_in switch/button pins; outputs drive io_out.
// PARAMETERS
//  DEBOUNCE_LEN    4         shift-register depth (>=2); all-ones sets level, all-zeros clears
//  CODE_W          6         width of code_in
//  NUM_STEPS       4         sequence length (>=2)
//  CODE_SEQ        24'h03F285  NUM_STEPS*CODE_W bits; step i = CODE_SEQ[i*CODE_W +: CODE_W]
//                            (default: step0=5, step1=10, step2=63, step3=0)
//  MAX_FAILS       3         consecutive mismatches that trigger lockout (>=2)
//  TIMER_W         16        timer width
//  OPEN_CYCLES     8         open duration, 1..2^TIMER_W-1
//  LOCKOUT_CYCLES  16        lockout duration, 1..2^TIMER_W-1
// PORTS
//  clk       in   1                    single clock, all state on rising edge
//  rst_n     in   1                    asynchronous active-low reset
//  step_in   in   1                    raw (bouncy) step button
//  code_in   in   CODE_W               switch code, must be stable when a step event fires
//  unlocked  out  1                    high while state==OPEN
//  lockout   out  1                    high while state==LOCKOUT
//  step_idx  out  $clog2(NUM_STEPS)    index of the next expected sequence entry
//  fail_cnt  out  $clog2(MAX_FAILS)    consecutive mismatch count
//  deb_level out  1                    debounced step level
//  err_pulse out  1                    1-cycle pulse on every mismatch
// BEHAVIOUR
//  Reset (async, rst_n=0): shift reg=0, deb_level=0, state=ARMED, step_idx=0, fail_cnt=0,
//    timer=0, err_pulse=0; unlocked=lockout=0. Release is synchronous to the next edge.
//  Debounce: sr <= {sr[DEBOUNCE_LEN-2:0], step_in} every cycle. deb_level <= 1 when sr is
//    all-ones, <= 0 when all-zeros, otherwise holds (hysteresis).
//  step_evt = (sr all-ones) & ~deb_level (combinational). The FSM acts on the same edge
//    that sets deb_level. step_in high from edge k -> FSM update at edge k+DEBOUNCE_LEN.
//  One event per press. Bounces shorter than DEBOUNCE_LEN never generate a second event.
//  code_in is sampled only at the step_evt edge; it is not debounced.
//  FSM, ARMED, on step_evt:
//    match, step_idx<NUM_STEPS-1: step_idx++.
//    match, step_idx==NUM_STEPS-1: ->OPEN, step_idx=0, fail_cnt=0, timer=OPEN_CYCLES-1.
//    mismatch: step_idx=0, err_pulse=1 next cycle. If fail_cnt==MAX_FAILS-1:
//      ->LOCKOUT, fail_cnt=0, timer=LOCKOUT_CYCLES-1. Otherwise fail_cnt++.
//  OPEN: timer decrements each cycle; at timer==0 ->ARMED on the next edge.
//    A step_evt in OPEN relocks immediately (->ARMED). The event is consumed, no compare.
//  LOCKOUT: step_evt ignored (no compare, no err_pulse); timer decrements; at 0 ->ARMED.
//  unlocked is high for exactly OPEN_CYCLES cycles; lockout for exactly LOCKOUT_CYCLES.
//  Debouncer runs in every state, so a button held across the lockout exit does not fire.
//  Reset mid-sequence or mid-timer returns to reset values; no partial progress is kept.
// TESTING (DEBOUNCE_LEN=4, defaults otherwise)
//  1. Press with codes 5,10,63,0 -> step_idx 1,2,3,0; unlocked=1 four cycles after the
//     last press edge, for exactly 8 cycles.
//  2. Sequence 5,10,7 -> err_pulse at step 3, step_idx=0, fail_cnt=1; then 5,10,63,0
//     -> unlocked=1, fail_cnt=0.
//  3. Three wrong presses -> fail_cnt 1,2 then lockout=1 for 16 cycles. A correct press
//     during lockout -> step_idx stays 0, no err_pulse.
//  4. step_in high 3 cycles then low; then 1010 toggling for 20 cycles -> deb_level
//     stays 0, no step_evt.
//  5. Held press, then one 1-cycle low glitch, then high again -> exactly one step
//     event; deb_level stays 1.
//  6. rst_n low asynchronously with step_idx=2 and mid-OPEN -> all outputs 0
//     immediately; next full correct sequence opens.

Source files
------------

// File: rtl/debounced_code_lock.sv
// debounced_code_lock
// Shift-register debouncer with hysteresis feeding a sequence-compare lock.
// Each clean press samples code_in against the next CODE_SEQ entry; a full
// correct sequence opens the lock for OPEN_CYCLES, and MAX_FAILS consecutive
// mismatches force a LOCKOUT_CYCLES lockout.
//
// Handshake: there is none. step_in is a raw level and code_in is a plain
// level. code_in is sampled only on the clock edge where a debounced press
// event fires (shift register just became all-ones while the debounced level
// was still low), so it must be stable around that edge.
module debounced_code_lock #(
  parameter int                            DEBOUNCE_LEN   = 4,
  parameter int                            CODE_W         = 6,
  parameter int                            NUM_STEPS      = 4,
  parameter logic [NUM_STEPS*CODE_W-1:0]   CODE_SEQ       = 24'h03F285,
  parameter int                            MAX_FAILS      = 3,
  parameter int                            TIMER_W        = 16,
  parameter int                            OPEN_CYCLES    = 8,
  parameter int                            LOCKOUT_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          step_in,
  input  logic [CODE_W-1:0]             code_in,
  output logic                          unlocked,
  output logic                          lockout,
  output logic [$clog2(NUM_STEPS)-1:0]  step_idx,
  output logic [$clog2(MAX_FAILS)-1:0]  fail_cnt,
  output logic                          deb_level,
  output logic                          err_pulse
);

  localparam int IDX_W  = $clog2(NUM_STEPS);
  localparam int FAIL_W = $clog2(MAX_FAILS);

  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_STEPS - 1);
  localparam logic [FAIL_W-1:0]  LAST_FAIL = FAIL_W'(MAX_FAILS - 1);
  localparam logic [TIMER_W-1:0] OPEN_LOAD = TIMER_W'(OPEN_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LOCK_LOAD = TIMER_W'(LOCKOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_ARMED   = 2'd0,
    S_OPEN    = 2'd1,
    S_LOCKOUT = 2'd2
  } state_e;

  logic [DEBOUNCE_LEN-1:0] sr_q, sr_d;
  logic                    deb_q, deb_d;
  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [FAIL_W-1:0]       fail_q, fail_d;
  logic [TIMER_W-1:0]      timer_q, timer_d;
  logic                    err_q, err_d;

  logic                    sr_all_ones;
  logic                    sr_all_zeros;
  logic                    step_evt;
  logic                    code_match;
  logic [CODE_W-1:0]       seq_tbl [NUM_STEPS];

  // Unpack the flat code sequence into a per-step lookup table.
  for (genvar g = 0; g < NUM_STEPS; g++) begin : g_seq
    assign seq_tbl[g] = CODE_SEQ[g*CODE_W +: CODE_W];
  end

  assign sr_all_ones  = &sr_q;
  assign sr_all_zeros = ~|sr_q;
  // A press is recognised on the edge that raises the debounced level.
  assign step_evt     = sr_all_ones & ~deb_q;
  assign code_match   = (code_in == seq_tbl[idx_q]);

  // Debouncer next state: shift in the raw input, level changes only on a
  // full run of ones or zeros, otherwise it holds.
  always_comb begin
    sr_d  = {sr_q[DEBOUNCE_LEN-2:0], step_in};
    deb_d = deb_q;
    if (sr_all_ones) begin
      deb_d = 1'b1;
    end else if (sr_all_zeros) begin
      deb_d = 1'b0;
    end
  end

  // Debouncer registers; they run in every lock state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q  <= '0;
      deb_q <= 1'b0;
    end else begin
      sr_q  <= sr_d;
      deb_q <= deb_d;
    end
  end

  // Lock FSM next state: compare on press events, run the open/lockout timer.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    fail_d  = fail_q;
    timer_d = timer_q;
    err_d   = 1'b0;
    case (state_q)
      S_ARMED: begin
        if (step_evt) begin
          if (code_match) begin
            if (idx_q == LAST_IDX) begin
              state_d = S_OPEN;
              idx_d   = '0;
              fail_d  = '0;
              timer_d = OPEN_LOAD;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            idx_d = '0;
            err_d = 1'b1;
            if (fail_q == LAST_FAIL) begin
              state_d = S_LOCKOUT;
              fail_d  = '0;
              timer_d = LOCK_LOAD;
            end else begin
              fail_d = fail_q + FAIL_W'(1);
            end
          end
        end
      end
      S_OPEN: begin
        // Any press while open relocks at once; the press is not compared.
        if (step_evt) begin
          state_d = S_ARMED;
          timer_d = '0;
        end else if (timer_q == '0) begin
          state_d = S_ARMED;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      S_LOCKOUT: begin
        // Presses are swallowed during lockout.
        if (timer_q == '0) begin
          state_d = S_ARMED;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      default: begin
        state_d = S_ARMED;
        idx_d   = '0;
        fail_d  = '0;
        timer_d = '0;
      end
    endcase
  end

  // Lock FSM registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_ARMED;
      idx_q   <= '0;
      fail_q  <= '0;
      timer_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      fail_q  <= fail_d;
      timer_q <= timer_d;
      err_q   <= err_d;
    end
  end

  assign unlocked  = (state_q == S_OPEN);
  assign lockout   = (state_q == S_LOCKOUT);
  assign step_idx  = idx_q;
  assign fail_cnt  = fail_q;
  assign deb_level = deb_q;
  assign err_pulse = err_q;

endmodule
